// File: rtl/rgb_frame_loader_pkg.sv
// Shared frame geometry, address width and loader state encoding.
// Used by the frame loader and by the display read logic.
package rgb_frame_loader_pkg;

  localparam int FRAME_W_DEFAULT = 200;
  localparam int FRAME_H_DEFAULT = 200;
  localparam int PIXELS          = FRAME_W_DEFAULT * FRAME_H_DEFAULT;
  localparam int ADDR_W          = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_R = 3'd1,
    GET_G = 3'd2,
    GET_B = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } loader_state_t;

  function automatic logic [ADDR_W-1:0] last_addr(input int w, input int h);
    return ADDR_W'(w * h - 1);
  endfunction

endpackage

// File: rtl/rgb_frame_loader.sv
// Collects R,G,B bytes from a valid/ready stream and writes each pixel into
// three parallel frame-buffer lanes at a common, monotonically rising address.
module rgb_frame_loader
  import rgb_frame_loader_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEFAULT,
  parameter int FRAME_H = FRAME_H_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] R_PORTA_addr,
  output logic [ADDR_W-1:0] G_PORTA_addr,
  output logic [ADDR_W-1:0] B_PORTA_addr,
  output logic [7:0]        R_PORTA_dout,
  output logic [7:0]        G_PORTA_dout,
  output logic [7:0]        B_PORTA_dout,
  output logic              R_PORTA_wea,
  output logic              G_PORTA_wea,
  output logic              B_PORTA_wea,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pixel_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = last_addr(FRAME_W, FRAME_H);

  if (FRAME_W * FRAME_H > 65536) begin : g_frame_too_large
    $error("rgb_frame_loader: FRAME_W*FRAME_H exceeds the 16-bit address space");
  end

  loader_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        r_q, g_q, b_q;
  logic              wea;
  logic              xfer;

  assign xfer = in_valid && in_ready;

  // Write enables are registered; address and data come straight from registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      wea         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      addr        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      wea        <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        // A B-byte transfer in this cycle never reaches WRITE, so its write is dropped.
        state    <= IDLE;
        in_ready <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              pixel_count <= '0;
              addr        <= '0;
              state       <= GET_R;
              in_ready    <= 1'b1;
              busy        <= 1'b1;
            end
          end
          GET_R: begin
            if (xfer) begin
              r_q   <= in_data;
              state <= GET_G;
            end
          end
          GET_G: begin
            if (xfer) begin
              g_q   <= in_data;
              state <= GET_B;
            end
          end
          GET_B: begin
            if (xfer) begin
              b_q      <= in_data;
              state    <= WRITE;
              in_ready <= 1'b0;
              wea      <= 1'b1;
            end
          end
          WRITE: begin
            pixel_count <= pixel_count + 1'b1;
            if (addr == LAST_ADDR) begin
              // Address parks on the last location instead of wrapping.
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              addr     <= addr + 1'b1;
              state    <= GET_R;
              in_ready <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign R_PORTA_addr = addr;
  assign G_PORTA_addr = addr;
  assign B_PORTA_addr = addr;
  assign R_PORTA_dout = r_q;
  assign G_PORTA_dout = g_q;
  assign B_PORTA_dout = b_q;
  assign R_PORTA_wea  = wea;
  assign G_PORTA_wea  = wea;
  assign B_PORTA_wea  = wea;

endmodule
